// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-writeback bus plus the decode-side read ports
// of the architectural register file.
interface writeback_regfile_if #(
    parameter int XLEN = 32
);
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;
    logic [XLEN-1:0] ExtImmW;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ResultW;

    modport master (
        output RegWriteW, ResultSrcW, RdW,
        output ALUResultW, ReadDataW, PCPlus4W, ExtImmW,
        output Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW
    );

    modport slave (
        input  RegWriteW, ResultSrcW, RdW,
        input  ALUResultW, ReadDataW, PCPlus4W, ExtImmW,
        input  Rs1D, Rs2D,
        output RD1D, RD2D, ResultW
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback result select and 32x32 integer register file with
// combinational read ports and write-through bypass.
module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic                clk,
    input logic                rst,
    writeback_regfile_if.slave wbBus
);
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] result;
    logic            we;
    logic            hit1;
    logic            hit2;
    logic            zero1;
    logic            zero2;

    always_comb begin
        result = wbBus.ALUResultW;
        case (wbBus.ResultSrcW)
            2'b00:   result = wbBus.ALUResultW;
            2'b01:   result = wbBus.ReadDataW;
            2'b10:   result = wbBus.PCPlus4W;
            default: result = wbBus.ExtImmW;
        endcase
    end

    assign we = wbBus.RegWriteW & ~rst & (wbBus.RdW != 5'd0);

    // Address compares depend only on indices, not on the result mux,
    // so they settle in parallel with ResultSrcW selection.
    assign hit1  = we && (wbBus.Rs1D == wbBus.RdW);
    assign hit2  = we && (wbBus.Rs2D == wbBus.RdW);
    assign zero1 = (wbBus.Rs1D == 5'd0);
    assign zero2 = (wbBus.Rs2D == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wbBus.RdW] <= result;
        end
    end

    always_comb begin
        wbBus.RD1D = regs[wbBus.Rs1D];
        if (zero1) begin
            wbBus.RD1D = '0;
        end else if (hit1) begin
            wbBus.RD1D = result;
        end
    end

    always_comb begin
        wbBus.RD2D = regs[wbBus.Rs2D];
        if (zero2) begin
            wbBus.RD2D = '0;
        end else if (hit2) begin
            wbBus.RD2D = result;
        end
    end

    assign wbBus.ResultW = result;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized checks of writeback_regfile against
// an array-based model of the architectural register file.
module tb_writeback_regfile;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] model [32];
    logic [31:0] lastRd1;
    logic [31:0] lastRd2;
    logic [31:0] lastRes;

    writeback_regfile_if #(.XLEN(32)) bus ();

    writeback_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .wbBus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w,
                         input logic [1:0] s, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst            = r;
        bus.RegWriteW  = w;
        bus.ResultSrcW = s;
        bus.RdW        = rd;
        bus.ALUResultW = alu;
        bus.ReadDataW  = ld;
        bus.PCPlus4W   = pc4;
        bus.ExtImmW    = imm;
        bus.Rs1D       = a1;
        bus.Rs2D       = a2;
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] a,
                                            input logic [31:0] res);
        bit commit;
        commit = bus.RegWriteW && !rst && bus.RdW != 0;
        if (a == 0) return 32'h0;
        if (commit && a == bus.RdW) return res;
        return model[a];
    endfunction

    // Check the current cycle against the model, then clock it in.
    task automatic step(input bit doChk);
        logic [31:0] srcVals [4];
        logic [31:0] expRes;
        #1;
        srcVals = '{bus.ALUResultW, bus.ReadDataW, bus.PCPlus4W,
                    bus.ExtImmW};
        expRes  = srcVals[bus.ResultSrcW];
        if (doChk) begin
            chk("result", bus.ResultW, expRes);
            chk("rd1", bus.RD1D, expRead(bus.Rs1D, expRes));
            chk("rd2", bus.RD2D, expRead(bus.Rs2D, expRes));
        end
        lastRd1 = bus.RD1D;
        lastRd2 = bus.RD2D;
        lastRes = bus.ResultW;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (bus.RegWriteW && bus.RdW != 0) begin
            model[bus.RdW] = expRes;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] muxExp [4];
        logic [4:0]  rd;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        muxExp = '{32'h11, 32'h22, 32'h33, 32'h44};
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(0);

        drive(0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        step(1);
        chk("preload_bypass", lastRd1, 32'hDEADBEEF);
        drive(1, 1, 0, 7, 32'h77, 0, 0, 0, 7, 5);
        step(1);
        chk("rst_rd1_nobypass", lastRd1, 32'h0);
        chk("rst_rd2_stored", lastRd2, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        step(1);
        chk("rst_x5_cleared", lastRd1, 32'h0);
        chk("rst_x7_dropped", lastRd2, 32'h0);

        for (int s = 0; s < 4; s++) begin
            drive(0, 1, 2'(s), 3, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0);
            step(1);
            chk("mux_sel", lastRes, muxExp[s]);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        step(1);
        chk("mux_commit_x3", lastRd1, 32'h44);

        drive(0, 1, 0, 10, 32'h12345678, 0, 0, 0, 10, 10);
        step(1);
        chk("bypass_rd1", lastRd1, 32'h12345678);
        chk("bypass_rd2", lastRd2, 32'h12345678);
        drive(0, 0, 0, 10, 0, 0, 0, 0, 10, 10);
        step(1);
        chk("stored_rd1", lastRd1, 32'h12345678);
        chk("stored_rd2", lastRd2, 32'h12345678);

        drive(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        step(1);
        chk("x0_same", lastRd1, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        chk("x0_next", lastRd1, 32'h0);

        drive(0, 1, 0, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 9, 32'h1, 0, 0, 0, 0, 9);
        step(1);
        chk("wdis_rd2", lastRd2, 32'hA5A5A5A5);

        drive(0, 1, 0, 4, 32'h1, 0, 0, 0, 4, 5);
        step(1);
        chk("b2b_rd1_0", lastRd1, 32'h1);
        chk("b2b_rd2_0", lastRd2, 32'h0);
        drive(0, 1, 0, 4, 32'h2, 0, 0, 0, 4, 5);
        step(1);
        chk("b2b_rd1_1", lastRd1, 32'h2);
        chk("b2b_rd2_1", lastRd2, 32'h0);
        drive(0, 1, 0, 5, 32'h3, 0, 0, 0, 4, 5);
        step(1);
        chk("b2b_rd1_2", lastRd1, 32'h2);
        chk("b2b_rd2_2", lastRd2, 32'h3);

        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), rd,
                  $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? rd
                      : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? rd
                      : 5'($urandom_range(0, 31)));
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file of the 5-stage RISC-V pipeline, directly downstream of the MEM/WB pipeline register. It selects the writeback result from the MEM/WB outputs, commits it to a 32 x 32-bit integer register file, and serves the two decode-stage read ports. Read ports are combinational with internal write-through bypass, so an instruction in ID sees a value being written in the same cycle without a separate falling-edge write. `ResultW` is also exported to the hazard/forwarding network feeding EX.

## Interface
Parameters:
- `XLEN`, 32, data width of registers and result.
- `NREGS`, 32, number of architectural registers; must equal 2^5 (address width fixed at 5).

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RegWriteW`  in  1  commit enable from MEM/WB.
- `ResultSrcW`  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 extended immediate.
- `RdW`  in  5  destination register index.
- `ALUResultW`  in  XLEN  ALU result.
- `ReadDataW`  in  XLEN  load data.
- `PCPlus4W`  in  XLEN  link address.
- `ExtImmW`  in  XLEN  extended immediate (LUI).
- `Rs1D`  in  5  decode read address 1.
- `Rs2D`  in  5  decode read address 2.
- `RD1D`  out  XLEN  read data 1.
- `RD2D`  out  XLEN  read data 2.
- `ResultW`  out  XLEN  selected writeback value (to forwarding mux in EX).

## Operation
- Result mux (combinational): `ResultW` = ALUResultW / ReadDataW / PCPlus4W / ExtImmW for ResultSrcW = 00/01/10/11. Full-width, no sign or zero manipulation here.
- Write qualifier: `we = RegWriteW & ~rst & (RdW != 0)`.
- On rising edge with `we`: `regs[RdW] <= ResultW`. Otherwise all registers hold.
- x0: never stored; reads of index 0 return 0 always, including via bypass.
- Read port n (n = 1,2), combinational:
  - RsnD == 0 -> 0.
  - else if `we` and RsnD == RdW -> `ResultW` (write-through bypass).
  - else -> `regs[RsnD]`.
- Both ports may read the same index, and both may hit the bypass in the same cycle; each resolves independently.
- Reset: on any rising edge with rst = 1, registers x1..x31 are cleared to 0; any pending write that cycle is dropped. While rst = 1 the bypass is disabled (`we` = 0), so reads return stored contents (0 after the first reset edge).
- Reset asserted mid-stream: the write presented in the reset cycle is lost; writes in cycles before the reset edge are already committed and are then cleared by it.
- Undefined ResultSrcW encodings do not exist (2-bit, all four decoded).

## Timing
- Write latency: value presented in cycle N is in `regs` after edge N; visible to readers in cycle N via bypass and in cycle N+1 from storage.
- Read latency: zero cycles (combinational from Rs1D/Rs2D, RdW, RegWriteW, ResultSrcW and data inputs).
- `ResultW`: combinational, zero latency from MEM/WB outputs.
- Output values after reset: RD1D/RD2D = 0 for every address until the first post-reset write; `ResultW` follows inputs (not reset-forced).
- No stall/flush inputs: stalls and bubbles arrive as RegWriteW = 0 from MEM/WB.
- Critical path: ResultSrcW -> result mux -> bypass mux -> RD1D/RD2D into ID/EX; keep the bypass compare off the mux-select path where possible.

## Test plan
- Reset: pre-load x5 = 0xDEADBEEF, assert rst 1 cycle with RegWriteW=1, RdW=7 -> after edge, read x5 = 0 and x7 = 0; RD1D=0 during reset even with Rs1D=7.
- Mux/commit: RegWriteW=1, RdW=3, ResultSrcW cycling 00..11 with ALU=0x11, Read=0x22, PC4=0x33, Imm=0x44 across 4 cycles -> ResultW each cycle equals the selected value; x3 = 0x44 after the last edge.
- Bypass: cycle N write x10 <= 0x12345678 with Rs1D=Rs2D=10 -> RD1D=RD2D=0x12345678 in cycle N; cycle N+1 with RegWriteW=0 -> still 0x12345678 from storage.
- x0: RegWriteW=1, RdW=0, ALUResultW=0xFFFFFFFF, Rs1D=0 -> RD1D=0 same cycle and next cycle.
- Write disabled: x9 = 0xA5A5A5A5, then RegWriteW=0, RdW=9, ALUResultW=0x1 with Rs2D=9 -> RD2D stays 0xA5A5A5A5, no bypass.
- Back-to-back: writes x4 <= 1, x4 <= 2, x5 <= 3 on consecutive cycles, Rs1D=4, Rs2D=5 -> RD1D = 1, 2, 2; RD2D = 0, 0, 3.
